// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that must hold values 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The sub port exists only when SERIAL_SUB_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin,
`ifdef SERIAL_SUB_EN
      output sub,
`endif
      output out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin,
`ifdef SERIAL_SUB_EN
      input  sub,
`endif
      input  out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_adder_fa_bit.sv
// Single-bit combinational full adder; the one arithmetic cell reused by serial_adder.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa_bit cell, LSB first, WIDTH cycles per add.
// Define SERIAL_SUB_EN to add a sub input selecting a - b (two's complement).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_r;
   logic             carry, cout_r;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum, fa_cout;
   logic             last_bit;
   logic [WIDTH:0]   sum_cat;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   fa_bit u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
   assign sum_cat  = {fa_sum, sum_sh};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
`ifdef SERIAL_SUB_EN
      b_load     = bus.sub ? ~bus.b : bus.b;
      carry_load = bus.sub ? 1'b1 : bus.cin;
`else
      b_load     = bus.b;
      carry_load = bus.cin;
`endif
   end

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = RUN;
         RUN:     if (last_bit)      state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state == RUN);
      bus.sum       = sum_r;
      bus.cout      = cout_r;
   end

   // NOTE: datapath registers are reset as well, so a reset mid-operation
   // leaves sum/cout at zero instead of exposing a partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_sh  <= bus.a;
               b_sh  <= b_load;
               carry <= carry_load;
               cnt   <= '0;
            end
            RUN: begin
               sum_sh <= sum_cat[WIDTH:1];
               carry  <= fa_cout;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sum_r  <= sum_cat[WIDTH:1];
                  cout_r <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed/table-driven bench for serial_adder (WIDTH=8); covers SERIAL_SUB_EN when defined.
module tb_serial_adder;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, measure latency, stall, release.
   task automatic do_op(input string name, input logic [7:0] a_i, input logic [7:0] b_i,
                        input logic cin_i, input logic sub_i, input int stall,
                        input logic [7:0] exp_sum, input logic exp_cout);
      int lat;
      int wait_cnt;
      wait_cnt = 0;
      while (!bus.in_ready && wait_cnt < 40) begin
         step();
         wait_cnt++;
      end
      if (!bus.in_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
      bus.a        = a_i;
      bus.b        = b_i;
      bus.cin      = cin_i;
`ifdef SERIAL_SUB_EN
      bus.sub      = sub_i;
`else
      if (sub_i) $display("note: sub requested without SERIAL_SUB_EN");
`endif
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         step();
         lat++;
      end
      check({name, "_latency"}, lat, WIDTH);
      check({name, "_sum"}, bus.sum, exp_sum);
      check({name, "_cout"}, bus.cout, exp_cout);
      repeat (stall) step();
      if (stall > 0) check({name, "_sum_held"}, bus.sum, exp_sum);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({name, "_released"}, bus.out_valid, 1'b0);
   endtask

   initial begin
      logic [8:0] full;
      logic [7:0] ra, rb;
      logic       rc;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
`ifdef SERIAL_SUB_EN
      bus.sub       = 1'b0;
`endif

      #12;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_sum", bus.sum, 8'h00);
      check("rst_cout", bus.cout, 1'b0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0,
               vecs[i].exp_sum, vecs[i].exp_cout);
      check("idle_keeps_sum", bus.sum, 8'hFF);

      // Backpressure with new operands offered while DONE
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.in_valid = 1'b1;
      step();
      bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
      repeat (WIDTH) step();
      check("bp_out_valid", bus.out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("bp_sum_%0d", i), bus.sum, 8'h46);
         check($sformatf("bp_cout_%0d", i), bus.cout, 1'b0);
         check($sformatf("bp_in_ready_%0d", i), bus.in_ready, 1'b0);
         check($sformatf("bp_valid_%0d", i), bus.out_valid, 1'b1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp_idle_in_ready", bus.in_ready, 1'b1);
      check("bp_idle_out_valid", bus.out_valid, 1'b0);
      check("bp_idle_busy", bus.busy, 1'b0);
      check("bp_not_captured", bus.sum, 8'h46);

      // Reset in the middle of RUN
      bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (3) step();
      check("mid_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1'b1);
      check("mid_rst_out_valid", bus.out_valid, 1'b0);
      check("mid_rst_sum", bus.sum, 8'h00);
      check("mid_rst_cout", bus.cout, 1'b0);
      check("mid_rst_busy", bus.busy, 1'b0);
      #2;
      rst_n = 1'b1;
      step();
      do_op("after_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 0, 8'h10, 1'b0);

      // Random sweep with random result stalls
      for (int i = 0; i < 200; i++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         do_op($sformatf("rnd%0d", i), ra, rb, rc, 1'b0, int'($urandom_range(0, 3)),
               full[7:0], full[8]);
      end

`ifdef SERIAL_SUB_EN
      do_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 0, 8'hFE, 1'b0);
      do_op("sub_7_5", 8'h07, 8'h05, 1'b0, 1'b1, 1, 8'h02, 1'b1);
      do_op("add_after_sub", 8'h07, 8'h05, 1'b1, 1'b0, 0, 8'h0D, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that reuses one single-bit full-adder cell over WIDTH cycles. A carry flip-flop holds the carry between bits.
- Sits directly on top of the full-adder cell. It feeds the cell one bit pair per clock, LSB first, and consumes the cell's sum and carry-out.
- Operands enter and results leave through valid/ready handshakes.
- Trades WIDTH cycles of latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, cin present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high while in RUN

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async, rst_n=0): state=IDLE; a_sh, b_sh, sum_sh, carry, cnt cleared to 0. Outputs after reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Reset asserted mid-RUN or in DONE abandons the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE. Encoding is a shared package enum.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a→a_sh, b→b_sh, cin→carry; cnt=0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN, each edge:
  - Cell inputs: a_sh[0], b_sh[0], carry.
  - Cell sum bit shifts into sum_sh MSB (sum_sh >> 1); cell carry-out → carry.
  - a_sh and b_sh shift right by 1; cnt+1.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th RUN edge), go to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; sum=sum_sh; cout=carry. Both are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready=0 in DONE, so accept and release never overlap. Minimum initiation interval is WIDTH+2 cycles.
- Latency: accept on edge E, out_valid high from edge E+WIDTH.
- sum and cout are registered and keep their last value in IDLE until the next result.
- WIDTH=1: RUN lasts exactly one edge.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of the MSB.

Optional Feature:
- Macro: SERIAL_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at accept.
  - If sub=1, b_sh loads ~b and carry loads 1; cin is ignored. Result = a - b mod 2^WIDTH; cout=1 means no borrow.
- When undefined: port absent; behaviour as above.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam function for counter width.
- One sub-module: fa_bit (a, b, cin → sum, cout), a pure combinational single-bit full adder instantiated once.
- FSM, shift registers and counter live in serial_adder.

Test Plan (WIDTH=8):
- a=0x00, b=0x00, cin=0 → out_valid exactly 8 edges after accept; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x5A, b=0xA5, cin=1 → sum=0x00, cout=1.
- Backpressure: result a=0x12, b=0x34 → sum=0x46. Hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands → sum/cout stable, in_ready=0, new operands not captured. Raise out_ready → IDLE next edge.
- Reset mid-op: accept a=0x0F, b=0x01, drop rst_n after 3 RUN edges → outputs immediately in_ready=1, out_valid=0, sum=0, cout=0. Next op a=0x0F, b=0x01 → sum=0x10.
- Back-to-back random sweep: 200 random (a, b, cin) with random out_ready stalls → every result equals a+b+cin; ordering preserved; no dropped or duplicated transactions.
- SERIAL_SUB_EN: a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0. Then a=0x07, b=0x05, sub=1 → sum=0x02, cout=1.
